// File: rtl/pc_gen_if.sv
// Fetch handshake bundle for pc_gen: request channel to memory, response channel
// back from memory, and the instruction/PC channel into the IF/ID register.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            req_ready;
  logic            rsp_valid;
  logic [31:0]     rsp_inst;
  logic            rsp_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_inst;
  logic            out_ready;

  modport master (
    output req_valid, req_addr, rsp_ready, out_valid, out_pc, out_inst,
    input  req_ready, rsp_valid, rsp_inst, out_ready
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, out_valid, out_pc, out_inst,
    output req_ready, rsp_valid, rsp_inst, out_ready
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: issues sequential fetches, tracks in-flight PCs, drops
// responses made stale by redirects. Optional perf counters: PC_GEN_PERF_CNT_EN.
module pc_gen #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(32'h8000_0000),
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter int unsigned     INST_BYTES      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_id_stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  pc_gen_if.master        bus,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     drop_cnt
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, stale_q;

  logic            redirect, drop, has_entry, push, pop;
  logic [XLEN-1:0] target;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Request issue and zero-latency response pass-through / drop decision
  always_comb begin
    redirect      = trap_valid | br_valid;
    target        = trap_valid ? trap_pc : br_pc;
    has_entry     = (count_q != '0);
    drop          = (stale_q != '0) | redirect;
    bus.req_valid = ~rst & ~redirect & ~if_id_stall & (count_q < CW'(MAX_OUTSTANDING));
    bus.req_addr  = pc_q;
    bus.rsp_ready = drop | bus.out_ready;
    bus.out_valid = ~rst & ~drop & bus.rsp_valid & has_entry;
    bus.out_pc    = has_entry ? fifo_q[rd_ptr_q] : '0;
    bus.out_inst  = has_entry ? bus.rsp_inst : '0;
    push          = bus.req_valid & bus.req_ready;
    pop           = bus.rsp_valid & bus.rsp_ready & has_entry;
  end

  // PC, occupancy and stale tracking; a redirect marks every surviving entry stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      stale_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (redirect) begin
        pc_q <= target;
      end else if (push) begin
        pc_q <= pc_q + XLEN'(INST_BYTES);
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (redirect) begin
        stale_q <= count_q - CW'(pop);
      end else if (pop && (stale_q != '0)) begin
        stale_q <= stale_q - CW'(1);
      end
    end
  end

  // PC storage needs no reset: out_pc is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= pc_q;
    end
  end

`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] redirect_q, drop_q;
  logic        dropped;

  assign dropped = pop & drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_q <= '0;
      drop_q     <= '0;
    end else begin
      if (redirect) redirect_q <= redirect_q + 32'd1;
      if (dropped)  drop_q     <= drop_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_q;
  assign drop_cnt     = drop_q;
`else
  assign redirect_cnt = '0;
  assign drop_cnt     = '0;
`endif

`ifndef SYNTHESIS
  // A response can only answer a request that is still outstanding
  a_rsp_has_req: assert property (@(posedge clk) disable iff (rst) bus.rsp_valid |-> (count_q != '0))
    else $error("pc_gen: rsp_valid with no outstanding request");
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, hand-written reset/wrap sequences, and
// randomized traffic checked against a queue-based model of in-flight fetches.
module tb_pc_gen;
  localparam int unsigned XLEN = 32;
  localparam int unsigned MAXO = 2;
`ifdef PC_GEN_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_valid, trap_valid;
  logic [31:0] br_pc, trap_pc;
  logic [31:0] redirect_cnt, drop_cnt;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_PC(32'h8000_0000), .MAX_OUTSTANDING(MAXO), .INST_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .if_id_stall(stall), .br_valid(br_valid), .br_pc(br_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .bus(bus),
    .redirect_cnt(redirect_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] perf_exp(input int unsigned v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: each in-flight fetch remembers its PC and whether a later redirect killed it
  typedef struct { logic [31:0] pc; bit stale; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  int unsigned m_red, m_drop;

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h8000_0000;
    m_red  = 0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit do_check);
    bit          redir     = trap_valid | br_valid;
    bit          nonempty  = (mq.size() != 0);
    bit          drop      = redir || (nonempty && mq[0].stale);
    bit          e_rv      = !redir && !stall && (mq.size() < MAXO);
    bit          e_rr      = drop || bus.out_ready;
    bit          e_ov      = bus.rsp_valid && nonempty && !drop;
    logic [31:0] e_opc     = nonempty ? mq[0].pc : 32'd0;
    if (do_check) begin
      chk("req_valid", bus.req_valid, e_rv);
      chk("req_addr", bus.req_addr, m_pc);
      chk("rsp_ready", bus.rsp_ready, e_rr);
      chk("out_valid", bus.out_valid, e_ov);
      chk("out_pc", bus.out_pc, e_opc);
      if (e_ov) chk("out_inst", bus.out_inst, bus.rsp_inst);
      chk("redirect_cnt", redirect_cnt, perf_exp(m_red));
      chk("drop_cnt", drop_cnt, perf_exp(m_drop));
    end
    if (bus.rsp_valid && e_rr && nonempty) begin
      if (drop) m_drop++;
      void'(mq.pop_front());
    end
    if (redir) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_pc = trap_valid ? trap_pc : br_pc;
      m_red++;
    end else if (e_rv && bus.req_ready) begin
      mq.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; br_valid = 1'b0; trap_valid = 1'b0; br_pc = '0; trap_pc = '0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_inst = '0; bus.out_ready = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    bus.req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req_valid", bus.req_valid, 1'b0);
    chk("rst req_addr", bus.req_addr, 32'h8000_0000);
    chk("rst out_valid", bus.out_valid, 1'b0);
    chk("rst out_pc", bus.out_pc, 32'd0);
    chk("rst redirect_cnt", redirect_cnt, 32'd0);
    chk("rst drop_cnt", drop_cnt, 32'd0);
    rst = 1'b0;
    bus.req_ready = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit stall, br, trap; logic [31:0] br_pc, trap_pc;
    bit req_ready, rsp_valid; logic [31:0] inst; bit out_ready;
    bit e_rv; logic [31:0] e_addr; bit e_rr, e_ov; logic [31:0] e_opc;
    int unsigned e_red, e_drop;
  } vec_t;

  vec_t vt[16];

  initial begin
    // stall br trap br_pc trap_pc | rq_rdy rsp inst out_rdy | req_valid req_addr rsp_ready out_valid out_pc red drop
    vt[0]  = '{1,0,0,32'h0,32'h0,          0,0,32'h0,1,          0,32'h8000_0000,1,0,32'h0,0,0};
    vt[1]  = '{0,0,0,32'h0,32'h0,          1,0,32'h0,1,          1,32'h8000_0000,1,0,32'h0,0,0};
    vt[2]  = '{0,0,0,32'h0,32'h0,          1,1,32'h1111_0013,1,  1,32'h8000_0004,1,1,32'h8000_0000,0,0};
    vt[3]  = '{0,0,0,32'h0,32'h0,          1,1,32'h2222_0013,1,  1,32'h8000_0008,1,1,32'h8000_0004,0,0};
    vt[4]  = '{0,0,0,32'h0,32'h0,          0,1,32'h3333_0013,1,  1,32'h8000_000C,1,1,32'h8000_0008,0,0};
    vt[5]  = '{0,0,0,32'h0,32'h0,          1,0,32'h0,1,          1,32'h8000_000C,1,0,32'h0,0,0};
    vt[6]  = '{0,0,0,32'h0,32'h0,          1,0,32'h0,1,          1,32'h8000_0010,1,0,32'h8000_000C,0,0};
    vt[7]  = '{0,0,0,32'h0,32'h0,          1,0,32'h0,1,          0,32'h8000_0014,1,0,32'h8000_000C,0,0};
    vt[8]  = '{0,1,0,32'h8000_0100,32'h0,  1,0,32'h0,1,          0,32'h8000_0014,1,0,32'h8000_000C,0,0};
    vt[9]  = '{0,0,0,32'h0,32'h0,          1,1,32'h4444_0013,1,  0,32'h8000_0100,1,0,32'h8000_000C,1,0};
    vt[10] = '{0,0,0,32'h0,32'h0,          1,1,32'h5555_0013,1,  1,32'h8000_0100,1,0,32'h8000_0010,1,1};
    vt[11] = '{0,0,0,32'h0,32'h0,          0,1,32'h6666_0013,1,  1,32'h8000_0104,1,1,32'h8000_0100,1,2};
    vt[12] = '{0,1,1,32'h8000_0200,32'h8000_0400, 1,0,32'h0,1,   0,32'h8000_0104,1,0,32'h0,1,2};
    vt[13] = '{0,0,0,32'h0,32'h0,          1,0,32'h0,1,          1,32'h8000_0400,1,0,32'h0,2,2};
    vt[14] = '{0,1,0,32'h8000_0800,32'h0,  1,1,32'h7777_0013,0,  0,32'h8000_0404,1,0,32'h8000_0400,2,2};
    vt[15] = '{1,0,0,32'h0,32'h0,          1,0,32'h0,0,          0,32'h8000_0800,0,0,32'h0,3,3};

    rst = 1'b1;
    idle_inputs();
    model_reset();
    apply_reset();

    // Directed vector table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      stall = vt[i].stall; br_valid = vt[i].br; trap_valid = vt[i].trap;
      br_pc = vt[i].br_pc; trap_pc = vt[i].trap_pc;
      bus.req_ready = vt[i].req_ready; bus.rsp_valid = vt[i].rsp_valid;
      bus.rsp_inst = vt[i].inst; bus.out_ready = vt[i].out_ready;
      #1;
      chk($sformatf("v%0d req_valid", i), bus.req_valid, vt[i].e_rv);
      chk($sformatf("v%0d req_addr", i), bus.req_addr, vt[i].e_addr);
      chk($sformatf("v%0d rsp_ready", i), bus.rsp_ready, vt[i].e_rr);
      chk($sformatf("v%0d out_valid", i), bus.out_valid, vt[i].e_ov);
      chk($sformatf("v%0d out_pc", i), bus.out_pc, vt[i].e_opc);
      if (vt[i].e_ov) chk($sformatf("v%0d out_inst", i), bus.out_inst, vt[i].inst);
      chk($sformatf("v%0d redirect_cnt", i), redirect_cnt, perf_exp(vt[i].e_red));
      chk($sformatf("v%0d drop_cnt", i), drop_cnt, perf_exp(vt[i].e_drop));
      model_step(1'b0);
    end

    // PC wrap at the top of the address space
    apply_reset();
    @(negedge clk); idle_inputs(); br_valid = 1'b1; br_pc = 32'hFFFF_FFFC; #1; model_step(1'b1);
    @(negedge clk); idle_inputs(); bus.req_ready = 1'b1; #1;
    chk("wrap req_addr0", bus.req_addr, 32'hFFFF_FFFC);
    model_step(1'b1);
    @(negedge clk); idle_inputs(); #1;
    chk("wrap req_addr1", bus.req_addr, 32'h0000_0000);
    model_step(1'b1);

    // Asynchronous reset in the middle of a burst
    apply_reset();
    repeat (2) begin
      @(negedge clk); idle_inputs(); bus.req_ready = 1'b1; #1; model_step(1'b1);
    end
    @(negedge clk); idle_inputs();
    bus.rsp_valid = 1'b1; bus.rsp_inst = inst_of(32'h8000_0000); #1;
    chk("pre-rst out_valid", bus.out_valid, 1'b1);
    chk("pre-rst out_pc", bus.out_pc, 32'h8000_0000);
    #1 rst = 1'b1;
    #1;
    chk("async rst out_valid", bus.out_valid, 1'b0);
    chk("async rst req_valid", bus.req_valid, 1'b0);
    chk("async rst req_addr", bus.req_addr, 32'h8000_0000);
    chk("async rst out_pc", bus.out_pc, 32'h0);
    bus.rsp_valid = 1'b0;
    @(negedge clk); rst = 1'b0; model_reset();
    @(negedge clk); idle_inputs(); bus.req_ready = 1'b1; #1;
    chk("post-rst req_addr", bus.req_addr, 32'h8000_0000);
    model_step(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      stall      = ($urandom_range(3) == 0);
      br_valid   = ($urandom_range(7) == 0);
      trap_valid = ($urandom_range(15) == 0);
      br_pc      = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      trap_pc    = $urandom() & 32'hFFFF_FFFC;
      bus.req_ready = ($urandom_range(3) != 0);
      bus.rsp_valid = (mq.size() != 0) && ($urandom_range(2) != 0);
      bus.rsp_inst  = bus.rsp_valid ? inst_of(mq[0].pc) : $urandom();
      bus.out_ready = ($urandom_range(3) != 0);
      #1;
      model_step(1'b1);
    end

    @(negedge clk); idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
